// File: rtl/pot_scanner_if.sv
// SPI bus shared by the two MCP3008-style potentiometer ADCs.
// The master drives the clock, command data and both chip selects.
// The ADCs drive the single shared data-return line.
interface pot_scanner_if;
  logic       adc_sclk;
  logic       adc_mosi;
  logic       adc_miso;
  logic [1:0] adc_cs_n;

  modport master (output adc_sclk, output adc_mosi, output adc_cs_n, input adc_miso);
  modport slave  (input adc_sclk, input adc_mosi, input adc_cs_n, output adc_miso);
endinterface

// File: rtl/pot_scanner.sv
// Round-robin scanner for twelve potentiometers read through two MCP3008-style ADCs.
// Each channel frame is SETUP, SHIFT (17 SCLK periods), HOLD, COMMIT and GAP.
// A new reading is committed only if it moves past the hysteresis band, lands
// on an endpoint, or is the first reading for that channel since reset.
module pot_scanner #(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned HYST    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en_i,
  pot_scanner_if.master        adc,
  output logic [119:0]         values_o,
  output logic                 update_o,
  output logic [3:0]           update_idx_o,
  output logic                 scan_done_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0]  HALF_LAST = 6'd33;
  localparam logic [5:0]  DATA_RISE = 6'd14;
  localparam logic [10:0] HYST_W    = 11'(HYST);
  localparam logic [3:0]  CHAN_LAST = 4'd11;

  logic [2:0]   state_q,  state_d;
  logic [7:0]   cnt_q,    cnt_d;
  logic [5:0]   half_q,   half_d;
  logic [3:0]   chan_q,   chan_d;
  logic         sclk_q,   sclk_d;
  logic         mosi_q,   mosi_d;
  logic [1:0]   cs_n_q,   cs_n_d;
  logic [9:0]   shift_q,  shift_d;
  logic [119:0] values_q, values_d;
  logic [11:0]  loaded_q, loaded_d;

  logic [9:0]   old_val;
  logic [10:0]  diff;
  logic         do_write;
  logic [5:0]   half_nx;
  logic [4:0]   period_nx;
  logic         cmd_bit;
  logic [3:0]   chan_nx;

  // Stored value of the channel being scanned and its distance to the new reading
  always_comb begin
    old_val = values_q[10*int'(chan_q) +: 10];
    if (shift_q >= old_val) diff = {1'b0, shift_q} - {1'b0, old_val};
    else                    diff = {1'b0, old_val} - {1'b0, shift_q};
  end

  // Commit decision: first load, outside the hysteresis band, or an endpoint change
  always_comb begin
    do_write = (state_q == S_COMMIT) &&
               (!loaded_q[chan_q] || (diff > HYST_W) ||
                (((shift_q == '0) || (shift_q == '1)) && (shift_q != old_val)));
  end

  // Command bit for the SCLK period that starts at the next falling edge
  always_comb begin
    half_nx   = half_q + 6'd1;
    period_nx = half_nx[5:1];
    chan_nx   = (chan_q == CHAN_LAST) ? '0 : chan_q + 4'd1;
    case (period_nx)
      5'd1:    cmd_bit = 1'b1;
      5'd2:    cmd_bit = chan_q[2];
      5'd3:    cmd_bit = chan_q[1];
      5'd4:    cmd_bit = chan_q[0];
      default: cmd_bit = 1'b0;
    endcase
  end

  // Frame sequencer, SPI waveform generation, data capture and commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    chan_d   = chan_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    shift_d  = shift_q;
    values_d = values_q;
    loaded_d = loaded_q;
    case (state_q)
      S_IDLE: begin
        if (scan_en_i) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          cs_n_d  = chan_q[3] ? 2'b01 : 2'b10;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          half_d  = '0;
          mosi_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!half_q[0]) begin
            // Rising edge: the last ten periods carry B9..B0
            if (half_q >= DATA_RISE) shift_d = {shift_q[8:0], adc.adc_miso};
            half_d = half_nx;
          end else if (half_q == HALF_LAST) begin
            state_d = S_HOLD;
            half_d  = '0;
            mosi_d  = 1'b0;
          end else begin
            // Falling edge: MOSI only moves while SCLK is low
            half_d = half_nx;
            mosi_d = cmd_bit;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_COMMIT;
          cnt_d   = '0;
          cs_n_d  = '1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_COMMIT: begin
        if (do_write) begin
          values_d[10*int'(chan_q) +: 10] = shift_q;
          loaded_d[chan_q]                = 1'b1;
        end
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          chan_d = chan_nx;
          if (scan_en_i) begin
            state_d = S_SETUP;
            cs_n_d  = chan_nx[3] ? 2'b01 : 2'b10;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = '1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      chan_q   <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= '1;
      shift_q  <= '0;
      values_q <= '0;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      chan_q   <= chan_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      shift_q  <= shift_d;
      values_q <= values_d;
      loaded_q <= loaded_d;
    end
  end

  assign adc.adc_sclk = sclk_q;
  assign adc.adc_mosi = mosi_q;
  assign adc.adc_cs_n = cs_n_q;

  // Pulses are decoded from the COMMIT state so they coincide with the write edge
  always_comb begin
    values_o     = values_q;
    update_o     = do_write;
    update_idx_o = do_write ? chan_q : '0;
    scan_done_o  = (state_q == S_COMMIT) && (chan_q == CHAN_LAST);
  end

endmodule

// File: tb/tb_pot_scanner.sv
// Directed bench for pot_scanner with a behavioural two-ADC model on the SPI bus.
module tb_pot_scanner;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scan_en = 1'b0;
  logic [119:0] values;
  logic         update;
  logic [3:0]   update_idx;
  logic         scan_done;

  pot_scanner_if spi ();

  pot_scanner #(.CLK_DIV(4), .HYST(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_en_i    (scan_en),
    .adc          (spi),
    .values_o     (values),
    .update_o     (update),
    .update_idx_o (update_idx),
    .scan_done_o  (scan_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] pot_val(input int k);
    return values[10*k +: 10];
  endfunction

  // Cycle counter and output monitors
  longint cyc = 0;
  always @(posedge clk) cyc++;

  int     upd_idx_q[$];
  longint upd_cyc_q[$];
  int     sd_cnt = 0;
  int     prot_err = 0;
  logic   prot_sclk_prev = 1'b0;
  logic   prot_mosi_prev = 1'b0;

  always @(negedge clk) begin
    if (update) begin
      upd_idx_q.push_back(int'(update_idx));
      upd_cyc_q.push_back(cyc);
    end
    if (scan_done) sd_cnt++;
    if (spi.adc_cs_n == 2'b00) prot_err++;
    if (spi.adc_cs_n == 2'b11 && spi.adc_sclk) prot_err++;
    if (spi.adc_sclk && prot_sclk_prev && (spi.adc_mosi !== prot_mosi_prev)) prot_err++;
    prot_sclk_prev = spi.adc_sclk;
    prot_mosi_prev = spi.adc_mosi;
  end

  // ADC model: decodes the 5-bit command, returns B9..B0 in periods 8-17
  logic [9:0] adc_val [12];
  logic [4:0] cmd_log [12];
  logic [1:0] cs_log  [12];
  int         frame_q[$];
  int         pcnt = 0;
  int         cur_frame = -1;
  logic [4:0] cmd = '0;
  logic       sclk_prev = 1'b0;
  logic [9:0] word;

  initial spi.adc_miso = 1'b0;

  always @(negedge clk) begin
    if (spi.adc_cs_n == 2'b11) begin
      pcnt = 0;
      cur_frame = -1;
      spi.adc_miso = 1'b0;
    end else if (spi.adc_sclk && !sclk_prev) begin
      pcnt++;
      if (pcnt <= 5) cmd = {cmd[3:0], spi.adc_mosi};
      if (pcnt == 5) begin
        cur_frame = (spi.adc_cs_n == 2'b10) ? int'(cmd[2:0]) : 8 + int'(cmd[2:0]);
        if (cur_frame < 12) begin
          cmd_log[cur_frame] = cmd;
          cs_log[cur_frame]  = spi.adc_cs_n;
        end
        frame_q.push_back(cur_frame);
      end
    end else if (!spi.adc_sclk && sclk_prev) begin
      if (pcnt >= 7 && pcnt <= 16 && cur_frame >= 0 && cur_frame < 12) begin
        word = adc_val[cur_frame];
        spi.adc_miso = word[16-pcnt];
      end else begin
        spi.adc_miso = 1'b0;
      end
    end
    sclk_prev = spi.adc_sclk;
  end

  task automatic wait_sd(input int target);
    int n = 0;
    while (sd_cnt < target && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (sd_cnt < target) check_val("timeout_scan_done", sd_cnt, target);
  endtask

  task automatic wait_frame(input int idx);
    int n = 0;
    while (cur_frame != idx && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (cur_frame != idx) check_val("timeout_frame", cur_frame, idx);
  endtask

  initial begin
    int n;
    int busy;
    int target;
    for (int k = 0; k < 12; k++) adc_val[k] = 10'd512;
    rst = 1'b1;
    scan_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_values", values, 0);
    check_val("rst_update", update, 0);
    check_val("rst_update_idx", update_idx, 0);
    check_val("rst_scan_done", scan_done, 0);
    check_val("rst_sclk", spi.adc_sclk, 0);
    check_val("rst_mosi", spi.adc_mosi, 0);
    check_val("rst_cs_n", spi.adc_cs_n, 2'b11);

    // First scan: every channel at 512, all load on first pass
    @(negedge clk) rst = 1'b0;
    wait_sd(1);
    #1;
    check_val("s1_upd_count", upd_idx_q.size(), 12);
    for (int k = 0; k < 12; k++) check_val($sformatf("s1_idx%0d", k), upd_idx_q[k], k);
    for (int k = 1; k < 12; k++)
      check_val($sformatf("s1_spacing%0d", k), upd_cyc_q[k] - upd_cyc_q[k-1], 149);
    check_val("s1_values", values, {12{10'd512}});
    check_val("s1_scan_done_once", sd_cnt, 1);
    check_val("s1_ch9_mosi", cmd_log[9], 5'b11001);
    check_val("s1_ch9_cs", cs_log[9], 2'b01);

    // Second scan: ch3 +1 stays inside band, ch5 and ch10 jump
    upd_idx_q.delete();
    upd_cyc_q.delete();
    adc_val[3]  = 10'd513;
    adc_val[5]  = 10'd2;
    adc_val[10] = 10'd1021;
    wait_sd(2);
    #1;
    check_val("s2_upd_count", upd_idx_q.size(), 2);
    check_val("s2_idx_a", upd_idx_q[0], 5);
    check_val("s2_idx_b", upd_idx_q[1], 10);
    check_val("s2_ch3_held", pot_val(3), 512);
    check_val("s2_ch5", pot_val(5), 2);
    check_val("s2_ch10", pot_val(10), 1021);

    // Third scan: ch3 outside band, endpoint moves of exactly HYST, ch6 at HYST
    upd_idx_q.delete();
    upd_cyc_q.delete();
    adc_val[3]  = 10'd515;
    adc_val[5]  = 10'd0;
    adc_val[6]  = 10'd514;
    adc_val[10] = 10'd1023;
    wait_sd(3);
    #1;
    check_val("s3_upd_count", upd_idx_q.size(), 3);
    check_val("s3_idx_a", upd_idx_q[0], 3);
    check_val("s3_idx_b", upd_idx_q[1], 5);
    check_val("s3_idx_c", upd_idx_q[2], 10);
    check_val("s3_ch3", pot_val(3), 515);
    check_val("s3_ch5", pot_val(5), 0);
    check_val("s3_ch6_held", pot_val(6), 512);
    check_val("s3_ch10", pot_val(10), 1023);

    // Drop scan_en during SHIFT of ch7: frame completes, then idle
    adc_val[7] = 10'd700;
    wait_frame(7);
    #1;
    scan_en = 1'b0;
    upd_idx_q.delete();
    upd_cyc_q.delete();
    n = 0;
    while (upd_idx_q.size() == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (upd_idx_q.size() == 0) check_val("timeout_upd7", 0, 1);
    #1;
    check_val("s4_idx", upd_idx_q[0], 7);
    check_val("s4_ch7", pot_val(7), 700);
    repeat (20) @(posedge clk);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi.adc_cs_n != 2'b11 || spi.adc_sclk) busy++;
    end
    check_val("s4_idle_busy", busy, 0);
    check_val("s4_idle_cs", spi.adc_cs_n, 2'b11);
    check_val("s4_no_more_upd", upd_idx_q.size(), 1);
    frame_q.delete();
    adc_val[8] = 10'd800;
    scan_en = 1'b1;
    n = 0;
    while (frame_q.size() == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (frame_q.size() == 0) check_val("timeout_frame8", 0, 1);
    check_val("s4_resume_ch", frame_q[0], 8);

    // Reset mid-SHIFT of ch2: outputs clear without a clock edge
    wait_frame(2);
    #2;
    rst = 1'b1;
    #1;
    check_val("s5_cs_n", spi.adc_cs_n, 2'b11);
    check_val("s5_sclk", spi.adc_sclk, 0);
    check_val("s5_mosi", spi.adc_mosi, 0);
    check_val("s5_values", values, 0);
    check_val("s5_update", update, 0);
    check_val("s5_scan_done", scan_done, 0);
    for (int k = 0; k < 12; k++) adc_val[k] = 10'd0;
    upd_idx_q.delete();
    upd_cyc_q.delete();
    frame_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    target = sd_cnt + 1;
    wait_sd(target);
    #1;
    check_val("s5_first_frame", frame_q[0], 0);
    check_val("s5_upd_count", upd_idx_q.size(), 12);
    for (int k = 0; k < 12; k++) check_val($sformatf("s5_idx%0d", k), upd_idx_q[k], k);
    check_val("s5_values_after", values, 0);

    check_val("protocol", prot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
